// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the parametrised UART receiver:
//               receiver state encoding, parity-mode constants and a helper
//               that computes the frame length in bit periods.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Value XOR-ed into the data parity to form the expected parity bit
  localparam logic c_parity_even = 1'b0;
  localparam logic c_parity_odd  = 1'b1;

  // Total bit periods in one frame: start + data + optional parity + stops
  function automatic int unsigned frame_bits(input int unsigned n_data,
                                             input int unsigned par_en,
                                             input int unsigned m_stop);
    return 1 + n_data + par_en + m_stop;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Line front end for the UART receiver. Two-flop synchroniser
//               (idle-high reset), falling-edge detector on the synchronised
//               line and a majority-of-3 voter around mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OS    = 16,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_rx_s,
  output logic             o_fall,
  output logic             o_bit_val
);

  localparam logic [CNT_W-1:0] c_cnt_s0 = CNT_W'(OS/2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_s1 = CNT_W'(OS/2);

  logic r_sync1;
  logic r_sync2;
  logic r_rx_d;
  logic r_s0;
  logic r_s1;

  // Bring the asynchronous line into the clock domain; reset to idle level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // One-cycle delayed copy of the synchronised line for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_d <= 1'b1;
    end else begin
      r_rx_d <= r_sync2;
    end
  end

  // Hold the first two votes; the third is the live line at the decision tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (i_tick) begin
      if (i_cnt == c_cnt_s0) r_s0 <= r_sync2;
      if (i_cnt == c_cnt_s1) r_s1 <= r_sync2;
    end
  end

  assign o_rx_s    = r_sync2;
  assign o_fall    = r_rx_d & ~r_sync2;
  assign o_bit_val = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver. Configurable data
//               width, parity, stop bits and oversampling factor; reports
//               parity, framing, break and overrun, and holds the last word
//               until the consumer acknowledges it with i_read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int N_DATA     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int M_STOP     = 1,
  parameter int OS         = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_rx,
  input  logic              i_read,
  output logic [N_DATA-1:0] o_data,
  output logic              o_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_break,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int c_cnt_w = $clog2(OS);
  localparam int c_idx_w = 4;

  localparam logic [c_cnt_w-1:0] c_cnt_decide = c_cnt_w'(OS/2 + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(OS - 1);
  localparam logic [c_idx_w-1:0] c_idx_data   = c_idx_w'(N_DATA - 1);
  localparam logic [c_idx_w-1:0] c_idx_stop   = c_idx_w'(M_STOP - 1);
  localparam logic               c_par_mode   = (PARITY_ODD != 0) ? c_parity_odd : c_parity_even;
  localparam logic               c_par_en     = (PARITY_EN != 0);

  rx_state_e r_state;
  rx_state_e w_next_state;

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [N_DATA-1:0]  r_shift;
  logic               r_par_bit;
  logic               r_ferr_acc;

  logic [N_DATA-1:0]  r_data;
  logic               r_valid;
  logic               r_perr;
  logic               r_ferr;
  logic               r_brk;
  logic               r_ovr;

  logic w_rx_s;
  logic w_fall;
  logic w_bit_val;
  logic w_decide;
  logic w_wrap;
  logic w_last_data;
  logic w_last_stop;
  logic w_commit;
  logic w_perr_now;
  logic w_ferr_now;
  logic w_brk_now;

  uart_rx_sampler #(
    .OS    (OS),
    .CNT_W (c_cnt_w)
  ) u_sampler (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx      (i_rx),
    .i_tick    (i_tick),
    .i_cnt     (r_cnt),
    .o_rx_s    (w_rx_s),
    .o_fall    (w_fall),
    .o_bit_val (w_bit_val)
  );

  assign w_decide    = i_tick & (r_cnt == c_cnt_decide);
  assign w_wrap      = i_tick & (r_cnt == c_cnt_last);
  assign w_last_data = (r_idx == c_idx_data);
  assign w_last_stop = (r_idx == c_idx_stop);

  // Frame status as it will be committed at the last stop decision
  assign w_ferr_now = r_ferr_acc | ~w_bit_val;
  assign w_perr_now = c_par_en & (r_par_bit ^ (^r_shift) ^ c_par_mode);
  assign w_brk_now  = (r_shift == '0) & (c_par_en ? ~r_par_bit : 1'b1) & w_ferr_now;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and commit decode
  always_comb begin
    w_next_state = r_state;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_next_state = ST_START;
      end
      ST_START: begin
        if (w_decide && w_bit_val) w_next_state = ST_IDLE;
        else if (w_wrap)           w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_wrap && w_last_data) w_next_state = c_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_wrap) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_decide && w_last_stop) begin
          w_commit     = 1'b1;
          w_next_state = (w_perr_now || w_ferr_now) ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line must not look like a fresh start edge
        if (w_rx_s) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bit timing, bit index, data shift register and stop-error accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ferr_acc <= 1'b0;
    end else if (i_tick) begin
      r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_w'(1);
      case (r_state)
        ST_DATA: begin
          if (w_decide) r_shift <= {w_bit_val, r_shift[N_DATA-1:1]};
          if (w_wrap)   r_idx   <= w_last_data ? '0 : r_idx + c_idx_w'(1);
        end
        ST_PARITY: begin
          if (w_decide) r_par_bit <= w_bit_val;
        end
        ST_STOP: begin
          if (w_decide && !w_bit_val) r_ferr_acc <= 1'b1;
          if (w_wrap)                 r_idx      <= r_idx + c_idx_w'(1);
        end
        default: ;
      endcase
    end
  end

  // Held output register with read handshake; a commit overrides a read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_commit) begin
      r_data  <= r_shift;
      r_perr  <= w_perr_now;
      r_ferr  <= w_ferr_now;
      r_brk   <= w_brk_now;
      r_ovr   <= r_valid & ~i_read;
      r_valid <= 1'b1;
    end else if (i_read && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_break      = r_brk;
  assign o_overrun    = r_ovr;
  assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Scoreboard bench for uart_rx_param. Three instances share the
//               clock and oversample tick: 8N1, 8E1 and 7N2. Expected commits
//               are queued by the stimulus; a monitor pops them whenever an
//               instance presents a new held word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    logic       ovr;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       line  = 1'b1;
  int         sel   = 0;
  logic [2:0] rx;
  logic [2:0] rd    = 3'b000;
  logic [2:0] auto_read = 3'b111;
  int         req_cnt [3];
  int         checks = 0;
  int         errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [7:0] a_data;
  logic [7:0] p_data;
  logic [6:0] s_data;
  logic [2:0] mvalid, mpe, mfe, mbrk, movr, mbusy;
  logic [8:0] mdata [3];

  assign rx[0] = (sel == 0) ? line : 1'b1;
  assign rx[1] = (sel == 1) ? line : 1'b1;
  assign rx[2] = (sel == 2) ? line : 1'b1;
  assign mdata[0] = {1'b0, a_data};
  assign mdata[1] = {1'b0, p_data};
  assign mdata[2] = {2'b00, s_data};

  uart_rx_param #(.N_DATA(8), .PARITY_EN(0), .PARITY_ODD(0), .M_STOP(1), .OS(OS)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[0]), .i_read(rd[0]),
    .o_data(a_data), .o_valid(mvalid[0]), .o_parity_err(mpe[0]), .o_frame_err(mfe[0]),
    .o_break(mbrk[0]), .o_overrun(movr[0]), .o_busy(mbusy[0]));

  uart_rx_param #(.N_DATA(8), .PARITY_EN(1), .PARITY_ODD(0), .M_STOP(1), .OS(OS)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[1]), .i_read(rd[1]),
    .o_data(p_data), .o_valid(mvalid[1]), .o_parity_err(mpe[1]), .o_frame_err(mfe[1]),
    .o_break(mbrk[1]), .o_overrun(movr[1]), .o_busy(mbusy[1]));

  uart_rx_param #(.N_DATA(7), .PARITY_EN(0), .PARITY_ODD(0), .M_STOP(2), .OS(OS)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[2]), .i_read(rd[2]),
    .o_data(s_data), .o_valid(mvalid[2]), .o_parity_err(mpe[2]), .o_frame_err(mfe[2]),
    .o_break(mbrk[2]), .o_overrun(movr[2]), .o_busy(mbusy[2]));

  always #5 clk = ~clk;

  // Oversample tick: one-cycle pulse every TICK_DIV clocks, driven off the sampling edge
  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % TICK_DIV;
      tick = (tdiv == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic exp_t mk(input logic [8:0] data, input logic pe, input logic fe,
                              input logic brk, input logic ovr);
    exp_t e;
    e.data = data; e.pe = pe; e.fe = fe; e.brk = brk; e.ovr = ovr;
    return e;
  endfunction

  // Monitor: detects each commit, compares it against the scoreboard and issues reads
  initial begin
    exp_t       psig [3];
    exp_t       cur;
    exp_t       exp_e;
    logic [2:0] pv;
    int         done_cnt [3];
    pv = 3'b000;
    for (int d = 0; d < 3; d++) begin
      psig[d] = '0;
      done_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        cur = mk(mdata[d], mpe[d], mfe[d], mbrk[d], movr[d]);
        if (rd[d]) begin
          chk($sformatf("read_clears_valid_dut%0d", d), {31'd0, mvalid[d]}, 32'd0);
          rd[d] = 1'b0;
        end else if (mvalid[d] && (!pv[d] || cur != psig[d])) begin
          if (qsize(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit_dut%0d: got %0h expected none", d, cur);
          end else begin
            exp_e = pop(d);
            chk($sformatf("commit_dut%0d", d), {19'd0, cur}, {19'd0, exp_e});
          end
          if (auto_read[d]) rd[d] = 1'b1;
        end else if (req_cnt[d] != done_cnt[d]) begin
          done_cnt[d] = req_cnt[d];
          rd[d] = 1'b1;
        end
        pv[d]   = mvalid[d];
        psig[d] = cur;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    line = v;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input int nd, input logic [8:0] data, input bit pen,
                            input logic pbit, input int ns, input logic [1:0] stops);
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    for (int i = 0; i < ns; i++) send_bit(stops[i]);
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_dut%0d", d), qsize(d), 0);
    repeat (4) @(negedge clk);
  endtask

  // Absolute time limit
  initial begin
    #400us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    for (int d = 0; d < 3; d++) req_cnt[d] = 0;
    repeat (4) @(negedge clk);
    chk("rst_valid", {29'd0, mvalid}, 32'd0);
    chk("rst_data_a", {23'd0, mdata[0]}, 32'd0);
    chk("rst_flags_busy", {17'd0, mpe, mfe, mbrk, movr, mbusy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 single 0x03, consumed by the monitor's read
    sel = 0;
    push(0, mk(9'h003, 0, 0, 0, 0));
    send_frame(8, 9'h003, 0, 0, 1, 2'b11);
    send_bit(1'b1);
    wait_drain(0);
    chk("a_valid_after_read", {31'd0, mvalid[0]}, 32'd0);

    // Back to back with a read after each: no overrun
    push(0, mk(9'h003, 0, 0, 0, 0));
    push(0, mk(9'h00C, 0, 0, 0, 0));
    push(0, mk(9'h020, 0, 0, 0, 0));
    send_frame(8, 9'h003, 0, 0, 1, 2'b11);
    send_frame(8, 9'h00C, 0, 0, 1, 2'b11);
    send_frame(8, 9'h020, 0, 0, 1, 2'b11);
    send_bit(1'b1);
    wait_drain(0);

    // Back to back without reads: overrun from the second commit on
    auto_read[0] = 1'b0;
    push(0, mk(9'h003, 0, 0, 0, 0));
    push(0, mk(9'h00C, 0, 0, 0, 1));
    push(0, mk(9'h020, 0, 0, 0, 1));
    send_frame(8, 9'h003, 0, 0, 1, 2'b11);
    send_frame(8, 9'h00C, 0, 0, 1, 2'b11);
    send_frame(8, 9'h020, 0, 0, 1, 2'b11);
    send_bit(1'b1);
    wait_drain(0);
    chk("noread_valid_held", {31'd0, mvalid[0]}, 32'd1);
    req_cnt[0]++;
    repeat (4) @(negedge clk);
    chk("manual_read_valid", {31'd0, mvalid[0]}, 32'd0);
    auto_read[0] = 1'b1;

    // Four-tick low glitch: enters START then rejects it
    @(negedge clk);
    line = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    chk("glitch_busy", {31'd0, mbusy[0]}, 32'd1);
    wait_ticks(1);
    @(negedge clk);
    line = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clk);
    chk("glitch_idle", {30'd0, mbusy[0], mvalid[0]}, 32'd0);

    // Break: line low for three frame times
    push(0, mk(9'h000, 0, 1, 1, 0));
    @(negedge clk);
    line = 1'b0;
    wait_ticks(3 * int'(frame_bits(8, 0, 1)) * OS);
    @(negedge clk);
    chk("break_wait_high_busy", {31'd0, mbusy[0]}, 32'd1);
    line = 1'b1;
    wait_ticks(2);
    @(negedge clk);
    chk("break_released_idle", {31'd0, mbusy[0]}, 32'd0);
    wait_drain(0);
    push(0, mk(9'h055, 0, 0, 0, 0));
    send_frame(8, 9'h055, 0, 0, 1, 2'b11);
    send_bit(1'b1);
    wait_drain(0);

    // 8E1: 0xA5 has four ones, so parity bit 1 is wrong and 0 is right
    sel = 1;
    push(1, mk(9'h0A5, 1, 0, 0, 0));
    send_frame(8, 9'h0A5, 1, 1'b1, 1, 2'b11);
    send_bit(1'b1);
    push(1, mk(9'h0A5, 0, 0, 0, 0));
    send_frame(8, 9'h0A5, 1, 1'b0, 1, 2'b11);
    send_bit(1'b1);
    wait_drain(1);

    // 7N2 with the second stop bit low
    sel = 2;
    push(2, mk(9'h02A, 0, 1, 0, 0));
    send_frame(7, 9'h02A, 0, 0, 2, 2'b01);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_drain(2);
    chk("s_idle_after_ferr", {31'd0, mbusy[2]}, 32'd0);

    // Async reset in the middle of the data bits discards the frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    chk("s_busy_mid_frame", {31'd0, mbusy[2]}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s_reset_outputs", {16'd0, mdata[2], mvalid[2], mpe[2], mfe[2], mbrk[2], movr[2], mbusy[2]}, 32'd0);
    line = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push(2, mk(9'h041, 0, 0, 0, 0));
    send_frame(7, 9'h041, 0, 0, 2, 2'b11);
    send_bit(1'b1);
    wait_drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
